div_share_sched: RTL and testbench
==================================

// Module: div_share_sched
// PURPOSE
//  Round-robin scheduler sharing one pipelined divider core (free-running, fixed latency, no backpressure,
//  no reset) among N_REQ requesters, e.g. FFT bin-ratio and delta-normalise stages.
//  Tags each issue so results return in order to the issuing requester. Detects divide-by-zero.
//  Provides a drain/flush handshake so upstream stages can quiesce the divider.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  W            32  dividend/divisor/quotient width, signed two's complement
//  DOUT_W       64  width of divider result bus
//  Q_LSB        32  LSB of quotient field in result bus; quotient = div_dout_in[Q_LSB +: W]
//  DIV_LATENCY  36  cycles from div_tvalid_out high to matching div_dout_valid_in high (>=1)
// PORTS
//  clk_in             in   1          system clock (100 MHz)
//  rst_in             in   1          synchronous reset, active-low
//  req_valid_in       in   N_REQ      per-requester operand valid
//  req_ready_out      out  N_REQ      one-hot grant; transfer when valid&ready
//  req_dividend_in    in   N_REQ*W    packed dividends, requester i at [i*W +: W]
//  req_divisor_in     in   N_REQ*W    packed divisors
//  resp_valid_out     out  N_REQ      one-cycle result strobe to owning requester (no backpressure)
//  resp_quotient_out  out  W          shared result bus, valid with resp_valid_out
//  resp_dbz_out       out  1          result was divide-by-zero
//  flush_in           in   1          pulse: stop granting, drain in-flight ops
//  flush_done_out     out  1          one-cycle pulse when drained
//  div_tvalid_out     out  1          to divider s_axis_divisor_tvalid (dividend channel tied valid)
//  div_dividend_out   out  W          to divider dividend tdata
//  div_divisor_out    out  W          to divider divisor tdata
//  div_dout_valid_in  in   1          from divider m_axis_dout_tvalid
//  div_dout_in        in   DOUT_W     from divider m_axis_dout_tdata
//  err_out            out  1          sticky tag/result mismatch, cleared only by reset
// BEHAVIOUR
//  Reset (rst_in=0 at clk edge): all outputs 0, RR pointer -> N_REQ-1, tag pipe cleared, FSM -> WARM.
//  FSM: WARM -> RUN after DIV_LATENCY+1 cycles (counter); in WARM no grants, div_dout_valid_in ignored
//   (divider has no reset; stale results discarded, err_out not set).
//   RUN -> DRAIN on flush_in; DRAIN -> DONE when tag pipe empty and no response pending;
//   DONE -> RUN next cycle, flush_done_out=1 in DONE only. flush_in in WARM/DRAIN/DONE ignored.
//  Grant: RUN only; req_ready_out = one-hot of first requester with valid, searching from RR ptr+1
//   with wrap; ptr <- granted index on transfer. Max one transfer per cycle; ready may depend on valid.
//  Issue: operands registered; div_tvalid_out=1 exactly cycle t+1 after transfer at t. Tag
//   {valid, id[$clog2(N_REQ)-1:0], dbz} pushed into DIV_LATENCY-deep shift pipe same cycle.
//  Return: when div_dout_valid_in=1 and pipe head valid -> registered response next cycle:
//   resp_valid_out[id]=1, quotient = div_dout_in[Q_LSB +: W], resp_dbz_out=dbz.
//   Total latency transfer->resp_valid_out = DIV_LATENCY+2 cycles; back-to-back issue gives back-to-back results.
//  Mismatch (dout valid with head invalid, or head valid with dout invalid): err_out<=1; result/tag dropped.
//  dbz = (divisor==0), sampled at transfer. Operand W-bit signed; MIN/-1 overflow passed through unmodified.
//  Reset mid-operation: in-flight tags lost, no resp_valid_out for them; returns to WARM.
// CONFIGURATION
//  DIV_ZERO_SAT_EN defined: when dbz, quotient forced to +(2^(W-1)-1) if dividend>=0, else -(2^(W-1));
//   divisor still issued to keep tag alignment.
//  Not defined: quotient = raw divider output even when dbz; resp_dbz_out still driven.
// TESTING
//  Reset, hold all valid=0 for DIV_LATENCY+1 cycles while model emits dout_valid -> no resp, err_out=0.
//  Req0 9/3 single -> resp_valid_out=4'b0001 at +DIV_LATENCY+2, quotient=3, dbz=0.
//  Req0..3 all valid continuously, 40 ops -> grants rotate 0,1,2,3,...; each resp to its own id, order kept.
//  Req2 1111/0 -> dbz=1; with DIV_ZERO_SAT_EN quotient=32'h7FFF_FFFF; -5/0 -> 32'h8000_0000.
//  Issue 5 ops, pulse flush_in -> no new ready; flush_done_out one cycle after 5th resp; grants resume.
//  Model injects extra dout_valid in RUN with empty pipe -> err_out=1 and stays 1 until rst_in=0.

Source files
------------

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one free-running, fixed-latency pipelined divider among N_REQ requesters.
// Optional: `define DIV_ZERO_SAT_EN to saturate the quotient of divide-by-zero operations.
module div_share_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned W           = 32,
  parameter int unsigned DOUT_W      = 64,
  parameter int unsigned Q_LSB       = 32,
  parameter int unsigned DIV_LATENCY = 36
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [N_REQ-1:0]    req_valid_in,
  output logic [N_REQ-1:0]    req_ready_out,
  input  logic [N_REQ*W-1:0]  req_dividend_in,
  input  logic [N_REQ*W-1:0]  req_divisor_in,
  output logic [N_REQ-1:0]    resp_valid_out,
  output logic [W-1:0]        resp_quotient_out,
  output logic                resp_dbz_out,
  input  logic                flush_in,
  output logic                flush_done_out,
  output logic                div_tvalid_out,
  output logic [W-1:0]        div_dividend_out,
  output logic [W-1:0]        div_divisor_out,
  input  logic                div_dout_valid_in,
  input  logic [DOUT_W-1:0]   div_dout_in,
  output logic                err_out
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WCW = $clog2(DIV_LATENCY + 1) + 1;
  localparam int unsigned FCW = $clog2(DIV_LATENCY + 2) + 1;

  typedef enum logic [1:0] {
    S_WARM,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic           dbz;
`ifdef DIV_ZERO_SAT_EN
    logic           neg;
`endif
  } tag_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WCW-1:0]   r_warm_cnt;
  logic [IDW-1:0]   r_ptr;
  logic [FCW-1:0]   r_inflight;

  logic             w_found;
  logic [IDW-1:0]   w_gidx;
  logic [N_REQ-1:0] w_grant;
  logic [W-1:0]     w_sel_dividend;
  logic [W-1:0]     w_sel_divisor;
  tag_t             w_new_tag;
  tag_t             w_head;
  tag_t             r_tag_pipe [DIV_LATENCY+1];

  logic             r_div_tvalid;
  logic [W-1:0]     r_div_dividend;
  logic [W-1:0]     r_div_divisor;

  logic [W-1:0]     w_q;
  logic             w_take;
  logic             w_mismatch;
  logic [N_REQ-1:0] r_resp_valid;
  logic [W-1:0]     r_resp_q;
  logic             r_resp_dbz;
  logic             r_err;
  logic             w_unused_dout;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= S_WARM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A result counts as pending while its tag is still in the pipe or its data is on the bus.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WARM:  if (r_warm_cnt == WCW'(DIV_LATENCY)) w_next_state = S_RUN;
      S_RUN:   if (flush_in) w_next_state = S_DRAIN;
      S_DRAIN: if ((r_inflight == '0) && !div_dout_valid_in) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_RUN;
      default: w_next_state = S_WARM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_warm_cnt <= '0;
    end else if ((r_state == S_WARM) && (r_warm_cnt != WCW'(DIV_LATENCY))) begin
      r_warm_cnt <= r_warm_cnt + WCW'(1);
    end
  end

  // ---------------------------------------------------------------- grant
  always_comb begin
    int unsigned v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    if ((r_state == S_RUN) && !flush_in) begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        v_idx = (32'(r_ptr) + k) % N_REQ;
        if (!w_found && req_valid_in[v_idx]) begin
          w_found = 1'b1;
          w_gidx  = v_idx[IDW-1:0];
        end
      end
    end
  end

  assign w_grant        = w_found ? (N_REQ'(1) << w_gidx) : '0;
  assign req_ready_out  = w_grant;
  assign w_sel_dividend = req_dividend_in[w_gidx*W +: W];
  assign w_sel_divisor  = req_divisor_in[w_gidx*W +: W];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_ptr <= IDW'(N_REQ - 1);
    end else if (w_found) begin
      r_ptr <= w_gidx;
    end
  end

  // ---------------------------------------------------------------- issue
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_div_tvalid   <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
    end else begin
      r_div_tvalid <= w_found;
      if (w_found) begin
        r_div_dividend <= w_sel_dividend;
        r_div_divisor  <= w_sel_divisor;
      end
    end
  end

  assign div_tvalid_out   = r_div_tvalid;
  assign div_dividend_out = r_div_dividend;
  assign div_divisor_out  = r_div_divisor;

  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_found;
    w_new_tag.id    = w_gidx;
    w_new_tag.dbz   = (w_sel_divisor == '0);
`ifdef DIV_ZERO_SAT_EN
    w_new_tag.neg   = w_sel_dividend[W-1];
`endif
  end

  // Stage 0 is loaded at the transfer edge, so the head lines up with the divider
  // output DIV_LATENCY cycles after div_tvalid_out.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i <= DIV_LATENCY; i++) begin
        r_tag_pipe[i] <= '0;
      end
    end else begin
      r_tag_pipe[0] <= w_new_tag;
      for (int unsigned i = 1; i <= DIV_LATENCY; i++) begin
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  assign w_head = r_tag_pipe[DIV_LATENCY];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_inflight <= '0;
    end else if (w_found && !w_head.valid) begin
      r_inflight <= r_inflight + FCW'(1);
    end else if (!w_found && w_head.valid) begin
      r_inflight <= r_inflight - FCW'(1);
    end
  end

  // ---------------------------------------------------------------- return
  always_comb begin
    w_q = div_dout_in[Q_LSB +: W];
`ifdef DIV_ZERO_SAT_EN
    if (w_head.dbz) begin
      w_q = w_head.neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // The divider is never reset, so its output is meaningless until WARM has elapsed.
  assign w_take     = (r_state != S_WARM) && w_head.valid && div_dout_valid_in;
  assign w_mismatch = (r_state != S_WARM) && (w_head.valid != div_dout_valid_in);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_resp_valid <= '0;
      r_resp_q     <= '0;
      r_resp_dbz   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= w_take ? (N_REQ'(1) << w_head.id) : '0;
      if (w_take) begin
        r_resp_q   <= w_q;
        r_resp_dbz <= w_head.dbz;
      end
      if (w_mismatch) begin
        r_err <= 1'b1;
      end
    end
  end

  assign resp_valid_out    = r_resp_valid;
  assign resp_quotient_out = r_resp_q;
  assign resp_dbz_out      = r_resp_dbz;
  assign err_out           = r_err;
  assign flush_done_out    = (r_state == S_DONE);
  assign w_unused_dout     = ^div_dout_in;

endmodule

// File: tb/tb_div_share_sched.sv
// Randomized scoreboard bench for div_share_sched with a behavioural fixed-latency divider model.
`timescale 1ns/1ps
module tb_div_share_sched;

  localparam int N      = 4;
  localparam int W      = 32;
  localparam int DOUT_W = 64;
  localparam int Q_LSB  = 32;
  localparam int L      = 36;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic [N-1:0]      req_valid_in = '0;
  logic [N-1:0]      req_ready_out;
  logic [N*W-1:0]    req_dividend_in = '0;
  logic [N*W-1:0]    req_divisor_in = '0;
  logic [N-1:0]      resp_valid_out;
  logic [W-1:0]      resp_quotient_out;
  logic              resp_dbz_out;
  logic              flush_in = 1'b0;
  logic              flush_done_out;
  logic              div_tvalid_out;
  logic [W-1:0]      div_dividend_out;
  logic [W-1:0]      div_divisor_out;
  logic              div_dout_valid_in = 1'b0;
  logic [DOUT_W-1:0] div_dout_in = '0;
  logic              err_out;

  div_share_sched #(
    .N_REQ(N), .W(W), .DOUT_W(DOUT_W), .Q_LSB(Q_LSB), .DIV_LATENCY(L)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_dividend_in(req_dividend_in), .req_divisor_in(req_divisor_in),
    .resp_valid_out(resp_valid_out), .resp_quotient_out(resp_quotient_out),
    .resp_dbz_out(resp_dbz_out), .flush_in(flush_in), .flush_done_out(flush_done_out),
    .div_tvalid_out(div_tvalid_out), .div_dividend_out(div_dividend_out),
    .div_divisor_out(div_divisor_out), .div_dout_valid_in(div_dout_valid_in),
    .div_dout_in(div_dout_in), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic        dbz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
  } dop_t;
  dop_t dq[$];

  int rst_cyc      = -100000;
  bit inject_extra = 1'b0;

  bit          pend [N];
  logic [31:0] pa   [N];
  logic [31:0] pb   [N];
  logic [31:0] pq   [N];
  int ptr_m     = N - 1;
  int flush_cyc = -1;
  int done_cyc  = -1;
  int last_xfer = -1000;
  int n_xfer    = 0;

  function automatic logic [31:0] div_core(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic [31:0] exp_quot(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_ZERO_SAT_EN
    if (b == 32'h0) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return div_core(a, b);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider: free-running, fixed latency L, quotient in the upper word.
  always @(negedge clk_in) begin
    dop_t op;
    dq.push_back('{div_tvalid_out, div_dividend_out, div_divisor_out});
    div_dout_valid_in = 1'b0;
    div_dout_in       = {$urandom, $urandom};
    if (dq.size() > L) begin
      op = dq.pop_front();
      if (op.v === 1'b1) begin
        div_dout_valid_in = 1'b1;
        div_dout_in       = {div_core(op.a, op.b), $urandom};
      end
    end
    if (cyc >= rst_cyc - 1 && cyc <= rst_cyc + L) begin
      div_dout_valid_in = 1'b1;
      div_dout_in       = {$urandom, $urandom};
    end else if (inject_extra && !div_dout_valid_in) begin
      div_dout_valid_in = 1'b1;
      inject_extra      = 1'b0;
    end
  end

  exp_t m_e;
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && resp_valid_out !== '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid %b with no outstanding op, expected none (cycle %0d)",
                 resp_valid_out, cyc);
      end else begin
        m_e = sb.pop_front();
        check("resp{valid,quot,dbz,cycle}",
              64'({resp_valid_out, resp_quotient_out, resp_dbz_out, 16'(cyc)}),
              64'({4'(1 << m_e.id), m_e.q, m_e.dbz, 16'(m_e.cyc)}));
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    pq[i]   = q;
  endtask

  task automatic new_rand(input int i);
    logic [31:0] a, b;
    a = $urandom;
    case ($urandom_range(0, 7))
      0:       b = 32'h0;
      1:       b = 32'hFFFF_FFFF;
      2:       b = 32'($urandom_range(1, 15));
      3:       begin a = 32'h8000_0000; b = (($urandom & 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
      default: b = $urandom >> $urandom_range(0, 31);
    endcase
    set_op(i, a, b, exp_quot(a, b));
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic step(input bit flush = 1'b0);
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk_in);
    flush_in = flush;
    for (int i = 0; i < N; i++) begin
      req_valid_in[i]           = pend[i];
      req_dividend_in[i*W +: W] = pa[i];
      req_divisor_in[i*W +: W]  = pb[i];
    end
    if (flush) begin
      flush_cyc = cyc;
      done_cyc  = (last_xfer + L + 3 > cyc + 2) ? last_xfer + L + 3 : cyc + 2;
    end
    #1;
    g = -1;
    if (cyc >= rst_cyc + L + 1 && !(flush_cyc >= 0 && cyc >= flush_cyc && cyc <= done_cyc)) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && pend[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
    end
    exp_ready = (g < 0) ? '0 : N'(1 << g);
    check("ready", 64'(req_ready_out), 64'(exp_ready));
    check("flush_done", 64'(flush_done_out), 64'(cyc == done_cyc));
    if (g >= 0) begin
      sb.push_back('{g, pq[g], (pb[g] == 32'h0), cyc + L + 2});
      pend[g]   = 1'b0;
      ptr_m     = g;
      last_xfer = cyc;
      n_xfer++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in       = 1'b0;
    req_valid_in = '0;
    flush_in     = 1'b0;
    clear_pend();
    sb.delete();
    ptr_m        = N - 1;
    flush_cyc    = -1;
    done_cyc     = -1;
    last_xfer    = -1000;
    inject_extra = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_cyc = cyc + 1;
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("reset_state",
          64'({req_ready_out, resp_valid_out, resp_quotient_out, resp_dbz_out,
               flush_done_out, div_tvalid_out, err_out}), 64'(0));
  endtask

  task automatic drain();
    clear_pend();
    for (int i = 0; i < L + 10 && sb.size() != 0; i++) step();
    check("drain_outstanding", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pq[i] = '0;
    end

    // Warm-up with stale divider output: no grants, no responses, no error.
    do_reset();
    repeat (L + 1) step();
    check("warm_err", 64'(err_out), 64'(0));

    // Single op from requester 0.
    set_op(0, 32'd9, 32'd3, 32'd3);
    step();
    repeat (L + 4) step();
    check("single_done", 64'(sb.size()), 64'(0));

    // All requesters continuously valid, 40 ops.
    n_xfer = 0;
    for (int c = 0; c < 400 && n_xfer < 40; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) new_rand(i);
      step();
    end
    check("rotate_count", 64'(n_xfer), 64'(40));
    drain();

    // Divide-by-zero and MIN/-1 corner cases.
`ifdef DIV_ZERO_SAT_EN
    set_op(2, 32'd1111, 32'h0, 32'h7FFF_FFFF);
    step();
    set_op(2, -32'sd5, 32'h0, 32'h8000_0000);
`else
    set_op(2, 32'd1111, 32'h0, 32'hFFFF_FFFF);
    step();
    set_op(2, -32'sd5, 32'h0, 32'hFFFF_FFFF);
`endif
    step();
    set_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    step();
    drain();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i] && ($urandom_range(0, 2) == 0)) new_rand(i);
      step();
    end
    drain();

    // Flush after 5 ops, with requesters still asking.
    for (int k = 0; k < 5; k++) begin
      new_rand(k % N);
      step();
    end
    for (int i = 0; i < N; i++) new_rand(i);
    step(1'b1);
    repeat (L + 8) step();
    drain();

    // Spurious divider output sets a sticky error; reset clears it and loses in-flight ops.
    inject_extra = 1'b1;
    step();
    step();
    check("err_set", 64'(err_out), 64'(1));
    set_op(1, 32'd100, 32'd7, 32'd14);
    set_op(3, 32'd50, 32'd5, 32'd10);
    repeat (3) step();
    check("err_sticky", 64'(err_out), 64'(1));
    do_reset();
    repeat (L + 1) step();
    check("err_after_reset", 64'(err_out), 64'(0));
    set_op(3, -32'sd100, 32'd7, -32'sd14);
    step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
